// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle instruction sequencer driving a unified memory port and an
// external combinational ALU.
//
// Each instruction is fetched from memory, decoded into registered ALU operands, executed
// (register write-back, branch, or hand-off to a memory read/write phase), and the PC
// advanced. A 16-entry register file holds architectural state.
//
// Instruction word (low 32 bits of the fetched data):
//   [31:28] opcode  [27:24] cc  [23] imm  [22:12] src  [11:0] dst
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse; starts (or restarts from HALT) at PC 0
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_rdata, mem_ack   memory response
//   alu_opcode/cc/r1/r2  registered ALU inputs, updated only in DECODE
//   alu_result, alu_branch_valid, alu_halt  combinational ALU outputs
//   busy, halted, pc     status
module ctrl_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [3:0]            alu_opcode,
  output logic [3:0]            alu_cc,
  output logic [DATA_WIDTH-1:0] alu_r1,
  output logic [DATA_WIDTH-1:0] alu_r2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_branch_valid,
  input  logic                  alu_halt,
  output logic                  busy,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [3:0] OpNop = 4'd0;
  localparam logic [3:0] OpLd  = 4'd1;
  localparam logic [3:0] OpStr = 4'd2;
  localparam logic [3:0] OpBra = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpAdd = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpHlt = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMemRd,
    StMemWr,
    StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            alu_opcode_q, alu_opcode_d;
  logic [3:0]            alu_cc_q, alu_cc_d;
  logic [DATA_WIDTH-1:0] alu_r1_q, alu_r1_d;
  logic [DATA_WIDTH-1:0] alu_r2_q, alu_r2_d;
  logic [DATA_WIDTH-1:0] rf_q [16];
  logic [DATA_WIDTH-1:0] rf_d [16];

  // Instruction fields of the latched instruction
  logic [3:0]            op;
  logic [3:0]            cc;
  logic                  imm;
  logic [10:0]           src;
  logic [11:0]           dst;
  logic [DATA_WIDTH-1:0] src_ext;
  logic [DATA_WIDTH-1:0] dst_ext;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] pc_inc;

  always_comb begin
    op       = instr_q[31:28];
    cc       = instr_q[27:24];
    imm      = instr_q[23];
    src      = instr_q[22:12];
    dst      = instr_q[11:0];
    src_ext  = DATA_WIDTH'(src);
    dst_ext  = DATA_WIDTH'(dst);
    src_addr = ADDR_WIDTH'(src);
    dst_addr = ADDR_WIDTH'(dst);
    // Natural overflow of the ADDR_WIDTH adder gives the required wrap to 0
    pc_inc   = pc_q + ADDR_WIDTH'(1);
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wdata_d      = wdata_q;
    alu_opcode_d = alu_opcode_q;
    alu_cc_d     = alu_cc_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    rf_d         = rf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      StFetch: begin
        if (mem_ack) begin
          instr_d = mem_rdata[31:0];
          state_d = StDecode;
        end
      end

      StDecode: begin
        alu_opcode_d = op;
        alu_cc_d     = cc;
        // Branches hand the target to the ALU instead of a register value
        alu_r1_d     = (op == OpBra) ? dst_ext : rf_q[dst[3:0]];
        alu_r2_d     = imm ? src_ext : rf_q[src[3:0]];
        state_d      = StExec;
      end

      StExec: begin
        // Halt wins over every other effect of the instruction
        if ((op == OpHlt) || alu_halt) begin
          state_d = StHalt;
        end else begin
          case (op)
            OpLd: begin
              if (imm) begin
                rf_d[dst[3:0]] = alu_result;
                pc_d           = pc_inc;
                state_d        = StFetch;
              end else begin
                state_d = StMemRd;
              end
            end
            OpStr: begin
              wdata_d = alu_result;
              state_d = StMemWr;
            end
            OpBra: begin
              pc_d    = alu_branch_valid ? dst_addr : pc_inc;
              state_d = StFetch;
            end
            OpXor, OpAdd, OpShl, OpShr, OpCmp: begin
              rf_d[dst[3:0]] = alu_result;
              pc_d           = pc_inc;
              state_d        = StFetch;
            end
            default: begin
              // NOP and unused codes 10-15
              pc_d    = pc_inc;
              state_d = StFetch;
            end
          endcase
        end
      end

      StMemRd: begin
        if (mem_ack) begin
          rf_d[dst[3:0]] = mem_rdata;
          pc_d           = pc_inc;
          state_d        = StFetch;
        end
      end

      StMemWr: begin
        if (mem_ack) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end

      StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Memory port and status, decoded from registered state so an asynchronous
  // reset drops the request immediately
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StMemRd: begin
        mem_req  = 1'b1;
        mem_addr = src_addr;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_addr;
      end
      default: begin
        mem_req  = 1'b0;
      end
    endcase
    mem_wdata  = wdata_q;
    alu_opcode = alu_opcode_q;
    alu_cc     = alu_cc_q;
    alu_r1     = alu_r1_q;
    alu_r2     = alu_r2_q;
    busy       = (state_q != StIdle) && (state_q != StHalt);
    halted     = (state_q == StHalt);
    pc         = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      instr_q      <= '0;
      wdata_q      <= '0;
      alu_opcode_q <= '0;
      alu_cc_q     <= '0;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wdata_q      <= wdata_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cc_q     <= alu_cc_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: behavioural memory with programmable ack latency,
// a small ALU model, a table of single-instruction vectors and hand-written
// sequences for memory, wrap-around and reset corner cases.
module tb_ctrl_sequencer;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [3:0]    alu_opcode;
  logic [3:0]    alu_cc;
  logic [DW-1:0] alu_r1;
  logic [DW-1:0] alu_r2;
  logic [DW-1:0] alu_result;
  logic          alu_branch_valid;
  logic          alu_halt;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;

  ctrl_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .alu_opcode      (alu_opcode),
    .alu_cc          (alu_cc),
    .alu_r1          (alu_r1),
    .alu_r2          (alu_r2),
    .alu_result      (alu_result),
    .alu_branch_valid(alu_branch_valid),
    .alu_halt        (alu_halt),
    .busy            (busy),
    .halted          (halted),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0]   mem [4096];
  int            rd_delay  = 0;
  int            wr_delay  = 0;
  int            wait_cnt  = 0;
  logic          ack_force = 1'b0;
  int            wr_cnt    = 0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_req && (wait_cnt >= (mem_we ? wr_delay : rd_delay))) || ack_force;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_we && mem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  // ALU model; unknown/NOP opcodes return a marker so stray writes are visible
  always_comb begin
    alu_result       = 32'hBAD0_0000 | alu_r2;
    alu_branch_valid = 1'b0;
    alu_halt         = 1'b0;
    case (alu_opcode)
      4'd1, 4'd2: alu_result = alu_r2;
      4'd3:       alu_branch_valid = (alu_cc == 4'd0);
      4'd4:       alu_result = alu_r1 ^ alu_r2;
      4'd5:       alu_result = alu_r1 + alu_r2;
      4'd6:       alu_result = alu_r1 << alu_r2[4:0];
      4'd7:       alu_result = alu_r1 >> alu_r2[4:0];
      4'd9:       alu_result = (alu_r1 == alu_r2) ? 32'd1 : 32'd0;
      default:    alu_result = 32'hBAD0_0000 | alu_r2;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] cc,
                                      input logic imm, input logic [10:0] src,
                                      input logic [11:0] dst);
    return {op, cc, imm, src, dst};
  endfunction

  // Returns mid-cycle just after the edge that samples start
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for an accepted read (fetch or data read); returns at that cycle's negedge
  task automatic wait_read(input string name, output logic [AW-1:0] addr);
    bit found = 0;
    addr = '1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_ack) begin
        addr  = mem_addr;
        found = 1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: no accepted read seen, expected one within 100 cycles", name);
    end
  endtask

  task automatic wait_halt(input string name, output int cyc);
    cyc = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted) break;
      @(posedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic [3:0]    exp_op;
    logic [31:0]   exp_r1;
    logic [31:0]   exp_r2;
  } vec_t;

  vec_t          vecs[11];
  logic [AW-1:0] a;
  int            cyc;
  int            n;
  bit            stable;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    // Program state after the LD/HLT run: reg1=5, everything else 0
    vecs[0]  = '{12'h000, ins(4'd5, 4'd0, 1'b1, 11'h7FF, 12'd2),   4'd5, 32'h0,    32'h7FF};
    vecs[1]  = '{12'h001, ins(4'd4, 4'd0, 1'b0, 11'd1, 12'd2),     4'd4, 32'h7FF,  32'h5};
    vecs[2]  = '{12'h002, ins(4'd6, 4'd0, 1'b1, 11'd4, 12'd2),     4'd6, 32'h7FA,  32'h4};
    vecs[3]  = '{12'h003, ins(4'd3, 4'd0, 1'b0, 11'd0, 12'h010),   4'd3, 32'h10,   32'h0};
    vecs[4]  = '{12'h010, ins(4'd7, 4'd0, 1'b1, 11'd1, 12'd2),     4'd7, 32'h7FA0, 32'h1};
    vecs[5]  = '{12'h011, ins(4'd9, 4'd0, 1'b0, 11'd2, 12'd1),     4'd9, 32'h5,    32'h3FD0};
    vecs[6]  = '{12'h012, ins(4'd3, 4'd1, 1'b0, 11'd0, 12'h020),   4'd3, 32'h20,   32'h0};
    vecs[7]  = '{12'h013, ins(4'd12, 4'd0, 1'b1, 11'd3, 12'd1),    4'd12, 32'h0,   32'h3};
    vecs[8]  = '{12'h014, ins(4'd1, 4'd0, 1'b1, 11'h123, 12'd3),   4'd1, 32'h0,    32'h123};
    vecs[9]  = '{12'h015, ins(4'd0, 4'd0, 1'b0, 11'd3, 12'd1),     4'd0, 32'h0,    32'h123};
    vecs[10] = '{12'h016, ins(4'd8, 4'd0, 1'b0, 11'd1, 12'd2),     4'd8, 32'h3FD0, 32'h0};

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", {20'd0, pc}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_alu_r1", alu_r1, 32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", {31'd0, busy}, 32'd0);

    // LD imm then HLT: 7 cycles from start to halted
    mem[0] = ins(4'd1, 4'd0, 1'b1, 11'd5, 12'd1);
    mem[1] = ins(4'd8, 4'd0, 1'b0, 11'd0, 12'd1);
    pulse_start();
    wait_halt("ld_hlt", cyc);
    check("ld_hlt_cycles", cyc, 32'd7);
    check("ld_hlt_halted", {31'd0, halted}, 32'd1);
    check("ld_hlt_pc", {20'd0, pc}, 32'd1);
    check("ld_hlt_reg1", alu_r1, 32'd5);

    // Table-driven single instructions, restarted from HALT
    for (int i = 0; i < 11; i++) mem[vecs[i].pc] = vecs[i].instr;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      wait_read($sformatf("vec%0d_fetch", i), a);
      check($sformatf("vec%0d_fetch_addr", i), {20'd0, a}, {20'd0, vecs[i].pc});
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_opcode", i), {28'd0, alu_opcode}, {28'd0, vecs[i].exp_op});
      check($sformatf("vec%0d_r1", i), alu_r1, vecs[i].exp_r1);
      check($sformatf("vec%0d_r2", i), alu_r2, vecs[i].exp_r2);
    end
    @(negedge clk);
    check("vec_halted", {31'd0, halted}, 32'd1);
    check("vec_halt_pc", {20'd0, pc}, 32'h16);

    // LD from memory, ADD wrap to zero, STR, HLT
    mem[0]     = ins(4'd1, 4'd0, 1'b0, 11'h200, 12'd1);
    mem[1]     = ins(4'd5, 4'd0, 1'b1, 11'd1, 12'd1);
    mem[2]     = ins(4'd2, 4'd0, 1'b0, 11'd1, 12'h101);
    mem[3]     = ins(4'd8, 4'd0, 1'b0, 11'd0, 12'd0);
    mem[12'h200] = 32'hFFFF_FFFF;
    pulse_start();
    wait_read("add_f0", a);
    check("add_fetch0", {20'd0, a}, 32'h000);
    wait_read("add_ldrd", a);
    check("add_ld_addr", {20'd0, a}, 32'h200);
    wait_read("add_f1", a);
    check("add_fetch1", {20'd0, a}, 32'h001);
    @(negedge clk);
    @(negedge clk);
    check("add_exec_opcode", {28'd0, alu_opcode}, 32'd5);
    check("add_exec_r1", alu_r1, 32'hFFFF_FFFF);
    wait_read("add_f2", a);
    check("add_fetch2", {20'd0, a}, 32'h002);
    wait_halt("add_halt", cyc);
    check("add_wr_addr", {20'd0, wr_addr}, 32'h101);
    check("add_wr_data", wr_data, 32'h0);
    check("add_halt_pc", {20'd0, pc}, 32'd3);

    // STR with delayed ack: request held stable for 4 cycles
    mem[0]       = ins(4'd1, 4'd0, 1'b0, 11'h201, 12'd2);
    mem[1]       = ins(4'd2, 4'd0, 1'b0, 11'd2, 12'h100);
    mem[2]       = ins(4'd8, 4'd0, 1'b0, 11'd0, 12'd0);
    mem[12'h201] = 32'h0000_A5A5;
    wr_delay = 3;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) break;
    end
    n = 0;
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      if (!(mem_req && mem_we)) break;
      n++;
      if (mem_addr !== 12'h100 || mem_wdata !== 32'h0000_A5A5) stable = 0;
      if (mem_ack) break;
      @(negedge clk);
    end
    check("str_hold_cycles", n, 32'd4);
    check("str_stable", {31'd0, stable}, 32'd1);
    wait_halt("str_halt", cyc);
    check("str_wr_addr", {20'd0, wr_addr}, 32'h100);
    check("str_wr_data", wr_data, 32'h0000_A5A5);
    wr_delay = 0;

    // BRA to 0xFFF, NOP wraps to 0; start while busy ignored; reset in fetch wait
    mem[0]       = ins(4'd3, 4'd0, 1'b0, 11'd0, 12'hFFF);
    mem[12'hFFF] = 32'h0;
    pulse_start();
    wait_read("wrap_f0", a);
    check("wrap_fetch0", {20'd0, a}, 32'h000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_read("wrap_fFFF", a);
    check("wrap_fetchFFF", {20'd0, a}, 32'hFFF);
    @(negedge clk);
    rd_delay = 1000;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("wrap_fetch_addr", {20'd0, mem_addr}, 32'h000);
    check("wrap_fetch_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_pc", {20'd0, pc}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_alu", {28'd0, alu_opcode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_delay = 0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    check("late_ack_pc", {20'd0, pc}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);

    // Register file cleared by reset: reg2 held 0xA5A5 before
    mem[0] = ins(4'd8, 4'd0, 1'b0, 11'd0, 12'd2);
    pulse_start();
    wait_halt("clr_halt", cyc);
    check("clr_halted", {31'd0, halted}, 32'd1);
    check("clr_reg2", alu_r1, 32'd0);
    check("clr_opcode", {28'd0, alu_opcode}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, unified memory address width.
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins execution at PC 0.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_ack=1.
- mem_ack  in  1  request accepted or completed in this cycle.
- alu_opcode  out  4  opcode driven to the ALU.
- alu_cc  out  4  condition code driven to the ALU.
- alu_r1  out  DATA_WIDTH  ALU operand 1.
- alu_r2  out  DATA_WIDTH  ALU operand 2.
- alu_result  in  DATA_WIDTH  combinational ALU result.
- alu_branch_valid  in  1  ALU branch-taken flag.
- alu_halt  in  1  ALU halt flag.
- busy  out  1  1 in any state except IDLE and HALT.
- halted  out  1  1 in HALT.
- pc  out  ADDR_WIDTH  current program counter.

Function
REQ-004 The instruction format SHALL be [31:28] opcode, [27:24] cc, [23] imm, [22:12] src (11 bits), [11:0] dst (12 bits); bits wider than DATA_WIDTH 32 SHALL be zero.
REQ-005 The opcodes SHALL be NOP=0, LD=1, STR=2, BRA=3, XOR=4, ADD=5, SHL=6, SHR=7, HLT=8, CMP=9; codes 10-15 SHALL execute as NOP.
REQ-006 The block SHALL contain a 16-entry register file of DATA_WIDTH bits, cleared on reset, with no hardwired entries.
REQ-007 The FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEMRD, MEMWR, HALT.
REQ-008 In IDLE, start SHALL move the FSM to FETCH with pc=0; start SHALL be ignored in any other state except HALT.
REQ-009 In FETCH, the block SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on the edge where mem_ack=1, it SHALL latch mem_rdata as the instruction and go to DECODE; mem_ack may be high in the first cycle of mem_req.
REQ-010 In DECODE, the block SHALL register the ALU operands: alu_opcode=opcode, alu_cc=cc, alu_r1=reg[dst[3:0]] (BRA: zero-extended dst), alu_r2 = imm ? zero-extended src : reg[src[3:0]]; then go to EXEC.
REQ-011 In EXEC, the following SHALL apply by opcode:
- XOR/ADD/SHL/SHR/CMP/LD with imm=1: write reg[dst[3:0]] with alu_result.
- LD with imm=0: go to MEMRD.
- STR: go to MEMWR.
- BRA: if alu_branch_valid=1, set pc=dst[ADDR_WIDTH-1:0], else pc+1.
- HLT or alu_halt=1: go to HALT, pc unchanged.
- NOP: no write.
- All other non-memory cases: pc+1, then FETCH.
REQ-012 In MEMRD, the block SHALL drive mem_req=1, mem_we=0, mem_addr=zero-extended src; on mem_ack, it SHALL write reg[dst[3:0]]=mem_rdata, set pc+1, and go to FETCH.
REQ-013 In MEMWR, the block SHALL drive mem_req=1, mem_we=1, mem_addr=dst, mem_wdata=alu_result captured in EXEC; on mem_ack, it SHALL set pc+1 and go to FETCH.
REQ-014 mem_addr, mem_we, and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0; mem_req SHALL be 0 in DECODE, EXEC, IDLE, and HALT.
REQ-015 pc+1 SHALL wrap modulo 2^ADDR_WIDTH (4095 -> 0).
REQ-016 Minimum latency SHALL be 3 cycles per non-memory instruction and 4 cycles for LD-memory or STR, with zero-wait acks; each mem_ack wait cycle SHALL add one cycle.
REQ-017 In HALT, halted SHALL be 1; start SHALL restart at pc=0 in FETCH with register contents retained.
REQ-018 ALU outputs SHALL hold their last values outside DECODE.

Reset
REQ-019 When rst_n=0, the block SHALL immediately enter IDLE and drive pc=0, all registers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_*=0, busy=0, and halted=0.
REQ-020 Reset asserted mid-transaction SHALL drop mem_req without waiting for mem_ack; a later mem_ack SHALL be ignored.

Verification
REQ-021 Reset, start, mem[0]=LD imm src=5 dst=1, mem[1]=HLT, zero-wait memory -> reg1=5, halted=1, pc=1, 7 cycles from start to halted.
REQ-022 Program ADD with reg1=0xFFFFFFFF, imm 1 -> reg1=0, alu_opcode=5 during EXEC, pc advances by 1.
REQ-023 BRA cc=0 dst=0x010 at pc 3 -> next fetch address 0x010; BRA with alu_branch_valid=0 -> next fetch 4.
REQ-024 STR reg2=0xA5A5 to dst=0x100 with mem_ack delayed 3 cycles -> mem_we=1, mem_addr=0x100, mem_wdata=0xA5A5 held stable for 4 cycles.
REQ-025 BRA to 0xFFF, then NOP at 0xFFF -> next fetch address 0x000.
REQ-026 rst_n low during a FETCH wait -> mem_req=0 in the same cycle, pc=0, and IDLE; a start pulse during busy has no effect.
